// File: rtl/ram_responder.sv
// Memory-side responder of the ram_port protocol: word-addressed synchronous RAM
// with per-byte write enables, optional wait states and out-of-range reporting.
module ram_responder #(
    parameter int    ADDR_WIDTH  = 10,
    parameter int    DATA_WIDTH  = 32,
    parameter int    MEM_WORDS   = 1024,
    parameter int    WAIT_STATES = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic                    clk,
    input  logic                    n_reset,
    input  logic                    en,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    rvalid,
    output logic                    ready,
    output logic                    err
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_WORDS);
    localparam logic [3:0] WAIT_CNT_INIT =
        (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    typedef struct packed {
        logic                  we;
        logic [BE_W-1:0]       be;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    logic [DATA_WIDTH-1:0] mem [0:MEM_WORDS-1];

    state_t           state, state_next;
    logic [3:0]       count, count_next;
    req_t             req_q;
    req_t             cmp;
    logic             accept;
    logic             cmp_fire;
    logic             in_range;
    logic             mem_wr;
    logic [IDX_W-1:0] mem_idx;

    assign ready  = (state == IDLE);
    assign accept = en && ready;

    // Without wait states the access completes on the accepting edge using the
    // live request; otherwise it completes from the latched copy.
    always_comb begin
        if (WAIT_STATES == 0) begin
            cmp_fire = accept;
            cmp      = '{we: we, be: be, addr: addr, wdata: wdata};
        end else begin
            cmp_fire = (state == BUSY) && (count == 4'd0);
            cmp      = req_q;
        end
    end

    assign in_range = ({1'b0, cmp.addr} < MEM_LIMIT);
    assign mem_idx  = cmp.addr[IDX_W-1:0];
    assign mem_wr   = cmp_fire && cmp.we && in_range;

    // NOTE: every output of an always_comb gets a default first so no path
    // through the case leaves a value unassigned and infers a latch.
    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            IDLE: begin
                if (accept && (WAIT_STATES != 0)) begin
                    state_next = BUSY;
                    count_next = WAIT_CNT_INIT;
                end
            end
            BUSY: begin
                if (count == 4'd0) begin
                    state_next = IDLE;
                end else begin
                    count_next = count - 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register here samples the
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state  <= IDLE;
            count  <= 4'd0;
            req_q  <= '0;
            rdata  <= '0;
            rvalid <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_next;
            count  <= count_next;
            if (accept) begin
                req_q <= '{we: we, be: be, addr: addr, wdata: wdata};
            end
            rvalid <= cmp_fire && !cmp.we;
            err    <= cmp_fire && !in_range;
            if (cmp_fire && !cmp.we) begin
                rdata <= in_range ? mem[mem_idx] : '0;
            end
        end
    end

    // NOTE: the storage array has no reset; contents survive n_reset and the
    // array maps onto plain RAM without a per-word clear path.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int i = 0; i < BE_W; i++) begin
                if (cmp.be[i]) begin
                    mem[mem_idx][8*i +: 8] <= cmp.wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: three instances cover zero wait states with
// a 1000-word memory, three wait states, and two wait states with mid-access reset.
module tb_ram_responder;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          n_reset;
    logic          en    [3];
    logic          we    [3];
    logic [BW-1:0] be    [3];
    logic [AW-1:0] addr  [3];
    logic [DW-1:0] wdata [3];
    logic [DW-1:0] rdata [3];
    logic          rvalid[3];
    logic          ready [3];
    logic          err   [3];

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    ram_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_WORDS(1000), .WAIT_STATES(0)) dut0 (
        .clk(clk), .n_reset(n_reset), .en(en[0]), .we(we[0]), .be(be[0]), .addr(addr[0]),
        .wdata(wdata[0]), .rdata(rdata[0]), .rvalid(rvalid[0]), .ready(ready[0]), .err(err[0])
    );

    ram_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_WORDS(1024), .WAIT_STATES(3)) dut3 (
        .clk(clk), .n_reset(n_reset), .en(en[1]), .we(we[1]), .be(be[1]), .addr(addr[1]),
        .wdata(wdata[1]), .rdata(rdata[1]), .rvalid(rvalid[1]), .ready(ready[1]), .err(err[1])
    );

    ram_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_WORDS(1024), .WAIT_STATES(2)) dut2 (
        .clk(clk), .n_reset(n_reset), .en(en[2]), .we(we[2]), .be(be[2]), .addr(addr[2]),
        .wdata(wdata[2]), .rdata(rdata[2]), .rvalid(rvalid[2]), .ready(ready[2]), .err(err[2])
    );

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input int d, input logic e, input logic w, input logic [BW-1:0] b,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd);
        en[d]    = e;
        we[d]    = w;
        be[d]    = b;
        addr[d]  = a;
        wdata[d] = wd;
    endtask

    task automatic idle(input int d);
        drive(d, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic wait_ready(input int d);
        int n = 0;
        while (!ready[d] && n < 40) begin
            tick();
            n++;
        end
        tests++;
        if (ready[d] !== 1'b1) begin
            failed++;
            $display("FAIL wait_ready dut%0d: ready=%b required 1", d, ready[d]);
        end
    endtask

    task automatic wr(input int d, input logic [AW-1:0] a, input logic [DW-1:0] data,
                      input logic [BW-1:0] b);
        drive(d, 1'b1, 1'b1, b, a, data);
        tick();
        idle(d);
        wait_ready(d);
    endtask

    task automatic rd(input int d, input logic [AW-1:0] a, output logic [DW-1:0] data,
                      output logic v, output logic e);
        int n = 0;
        drive(d, 1'b1, 1'b0, '0, a, '0);
        tick();
        idle(d);
        while (!rvalid[d] && n < 40) begin
            tick();
            n++;
        end
        data = rdata[d];
        v    = rvalid[d];
        e    = err[d];
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        for (int d = 0; d < 3; d++) idle(d);
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            tests += 4;
            if (ready[d] !== 1'b1) begin
                failed++; $display("FAIL reset_ready dut%0d: got %b required 1", d, ready[d]);
            end
            if (rvalid[d] !== 1'b0) begin
                failed++; $display("FAIL reset_rvalid dut%0d: got %b required 0", d, rvalid[d]);
            end
            if (err[d] !== 1'b0) begin
                failed++; $display("FAIL reset_err dut%0d: got %b required 0", d, err[d]);
            end
            if (rdata[d] !== 32'h0) begin
                failed++; $display("FAIL reset_rdata dut%0d: got %h required 0", d, rdata[d]);
            end
        end
        n_reset = 1'b1;
        tick();
    endtask

    task automatic test_read_after_write();
        drive(0, 1'b1, 1'b1, 4'hF, 10'd5, 32'hCAFEBABE);
        tick();
        tests++;
        if (ready[0] !== 1'b1) begin
            failed++; $display("FAIL raw_ready_wr: got %b required 1", ready[0]);
        end
        drive(0, 1'b1, 1'b0, 4'h0, 10'd5, 32'h0);
        tick();
        idle(0);
        tests += 4;
        if (rvalid[0] !== 1'b1) begin
            failed++; $display("FAIL raw_rvalid: got %b required 1", rvalid[0]);
        end
        if (rdata[0] !== 32'hCAFEBABE) begin
            failed++; $display("FAIL raw_rdata: got %h required cafebabe", rdata[0]);
        end
        if (ready[0] !== 1'b1) begin
            failed++; $display("FAIL raw_ready_rd: got %b required 1", ready[0]);
        end
        if (err[0] !== 1'b0) begin
            failed++; $display("FAIL raw_err: got %b required 0", err[0]);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1'b1, 1'b1, 4'hF, 10'(10 + i), 32'h0000_0100 + 32'(i));
            tick();
            tests++;
            if (ready[0] !== 1'b1) begin
                failed++; $display("FAIL b2b_ready_wr%0d: got %b required 1", i, ready[0]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 1'b1, 1'b0, 4'h0, 10'(10 + i), 32'h0);
            tick();
            tests += 2;
            if (rvalid[0] !== 1'b1) begin
                failed++; $display("FAIL b2b_rvalid%0d: got %b required 1", i, rvalid[0]);
            end
            if (rdata[0] !== 32'h0000_0100 + 32'(i)) begin
                failed++;
                $display("FAIL b2b_rdata%0d: got %h required %h", i, rdata[0], 32'h100 + 32'(i));
            end
        end
        idle(0);
        tick();
        tests++;
        if (rvalid[0] !== 1'b0) begin
            failed++; $display("FAIL b2b_rvalid_end: got %b required 0", rvalid[0]);
        end
    endtask

    task automatic test_byte_enables();
        logic [DW-1:0] data;
        logic          v, e;
        wr(0, 10'd3, 32'h11223344, 4'hF);
        wr(0, 10'd3, 32'hAABBCCDD, 4'b0101);
        rd(0, 10'd3, data, v, e);
        tests += 2;
        if (data !== 32'h11BB33DD) begin
            failed++; $display("FAIL be_merge: got %h required 11bb33dd", data);
        end
        if (v !== 1'b1) begin
            failed++; $display("FAIL be_rvalid: got %b required 1", v);
        end
        wr(0, 10'd3, 32'hFFFFFFFF, 4'h0);
        rd(0, 10'd3, data, v, e);
        tests++;
        if (data !== 32'h11BB33DD) begin
            failed++; $display("FAIL be_zero_noop: got %h required 11bb33dd", data);
        end
    endtask

    task automatic test_out_of_range();
        logic [DW-1:0] data;
        logic          v, e;
        wr(0, 10'd0,   32'hA5A50000, 4'hF);
        wr(0, 10'd20,  32'h00005A5A, 4'hF);
        wr(0, 10'd999, 32'h00000999, 4'hF);
        rd(0, 10'd999, data, v, e);
        tests += 2;
        if (data !== 32'h00000999) begin
            failed++; $display("FAIL oor_last_word: got %h required 00000999", data);
        end
        if (e !== 1'b0) begin
            failed++; $display("FAIL oor_last_err: got %b required 0", e);
        end
        drive(0, 1'b1, 1'b0, 4'h0, 10'd1000, 32'h0);
        tick();
        tests += 3;
        if (rvalid[0] !== 1'b1) begin
            failed++; $display("FAIL oor_rd_rvalid: got %b required 1", rvalid[0]);
        end
        if (err[0] !== 1'b1) begin
            failed++; $display("FAIL oor_rd_err: got %b required 1", err[0]);
        end
        if (rdata[0] !== 32'h0) begin
            failed++; $display("FAIL oor_rd_rdata: got %h required 0", rdata[0]);
        end
        drive(0, 1'b1, 1'b1, 4'hF, 10'd1020, 32'hFFFFFFFF);
        tick();
        idle(0);
        tests += 2;
        if (err[0] !== 1'b1) begin
            failed++; $display("FAIL oor_wr_err: got %b required 1", err[0]);
        end
        if (rvalid[0] !== 1'b0) begin
            failed++; $display("FAIL oor_wr_rvalid: got %b required 0", rvalid[0]);
        end
        tick();
        tests++;
        if (err[0] !== 1'b0) begin
            failed++; $display("FAIL oor_err_clear: got %b required 0", err[0]);
        end
        rd(0, 10'd0, data, v, e);
        tests++;
        if (data !== 32'hA5A50000) begin
            failed++; $display("FAIL oor_mem0: got %h required a5a50000", data);
        end
        rd(0, 10'd20, data, v, e);
        tests++;
        if (data !== 32'h00005A5A) begin
            failed++; $display("FAIL oor_mem20: got %h required 00005a5a", data);
        end
    endtask

    task automatic test_wait_states();
        logic          exp_ready [8];
        logic          exp_rvalid[8];
        logic [DW-1:0] exp_rdata;
        exp_ready  = '{0, 0, 0, 1, 0, 0, 0, 1};
        exp_rvalid = '{0, 0, 0, 1, 0, 0, 0, 1};
        wr(1, 10'd7, 32'h12345678, 4'hF);
        wr(1, 10'd8, 32'h0BADF00D, 4'hF);
        drive(1, 1'b1, 1'b0, 4'h0, 10'd7, 32'h0);
        for (int c = 0; c < 8; c++) begin
            tick();
            tests += 2;
            if (ready[1] !== exp_ready[c]) begin
                failed++;
                $display("FAIL ws_ready c%0d: got %b required %b", c + 1, ready[1], exp_ready[c]);
            end
            if (rvalid[1] !== exp_rvalid[c]) begin
                failed++;
                $display("FAIL ws_rvalid c%0d: got %b required %b", c + 1, rvalid[1], exp_rvalid[c]);
            end
            if (c >= 3) begin
                exp_rdata = (c == 7) ? 32'h0BADF00D : 32'h12345678;
                tests++;
                if (rdata[1] !== exp_rdata) begin
                    failed++;
                    $display("FAIL ws_rdata c%0d: got %h required %h", c + 1, rdata[1], exp_rdata);
                end
            end
            if (c == 3) addr[1] = 10'd8;
        end
        idle(1);
        tick();
    endtask

    task automatic test_rdata_hold();
        wr(0, 10'd0, 32'h00000013, 4'hF);
        drive(0, 1'b1, 1'b0, 4'h0, 10'd0, 32'h0);
        for (int c = 0; c < 5; c++) begin
            tick();
            if (c == 0) idle(0);
            tests += 2;
            if (rdata[0] !== 32'h00000013) begin
                failed++; $display("FAIL hold_rdata c%0d: got %h required 00000013", c, rdata[0]);
            end
            if (rvalid[0] !== (c == 0)) begin
                failed++; $display("FAIL hold_rvalid c%0d: got %b required %b", c, rvalid[0], c == 0);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [DW-1:0] data;
        logic          v, e;
        wr(2, 10'd9, 32'h0, 4'hF);
        wr(2, 10'd4, 32'h55AA55AA, 4'hF);
        rd(2, 10'd4, data, v, e);
        tests++;
        if (data !== 32'h55AA55AA) begin
            failed++; $display("FAIL mr_pre_read: got %h required 55aa55aa", data);
        end
        drive(2, 1'b1, 1'b1, 4'hF, 10'd9, 32'hFFFFFFFF);
        tick();
        idle(2);
        tests++;
        if (ready[2] !== 1'b0) begin
            failed++; $display("FAIL mr_busy: got %b required 0", ready[2]);
        end
        n_reset = 1'b0;
        #1;
        tests += 3;
        if (ready[2] !== 1'b1) begin
            failed++; $display("FAIL mr_ready: got %b required 1", ready[2]);
        end
        if (rvalid[2] !== 1'b0) begin
            failed++; $display("FAIL mr_rvalid: got %b required 0", rvalid[2]);
        end
        if (rdata[2] !== 32'h0) begin
            failed++; $display("FAIL mr_rdata: got %h required 0", rdata[2]);
        end
        tick();
        tick();
        n_reset = 1'b1;
        tick();
        rd(2, 10'd9, data, v, e);
        tests += 2;
        if (data !== 32'h0) begin
            failed++; $display("FAIL mr_dropped_write: got %h required 0", data);
        end
        if (v !== 1'b1) begin
            failed++; $display("FAIL mr_post_rvalid: got %b required 1", v);
        end
        rd(2, 10'd4, data, v, e);
        tests++;
        if (data !== 32'h55AA55AA) begin
            failed++; $display("FAIL mr_mem_kept: got %h required 55aa55aa", data);
        end
    endtask

    initial begin
        test_reset();
        test_read_after_write();
        test_back_to_back();
        test_byte_enables();
        test_out_of_range();
        test_wait_states();
        test_rdata_hold();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
